// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the TMDS 8b/10b encoder: control symbols,
// disparity counter width, popcount and control-symbol lookup.
package tmds_pkg;

    localparam int CNT_W = 5;

    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b01:   s = CTL_01;
            2'b10:   s = CTL_10;
            2'b11:   s = CTL_11;
            default: s = CTL_00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tmds_encoder_n_if.sv
// Pixel-side bus of the NUM_CH-lane TMDS encoder.
// bal_err exists only when TMDS_BALANCE_MON_EN is defined.
interface tmds_encoder_n_if #(parameter int NUM_CH = 3) ();

    logic                  de;
    logic [8*NUM_CH-1:0]   data;
    logic [2*NUM_CH-1:0]   ctrl;
    logic [10*NUM_CH-1:0]  symbol;
    logic                  de_o;

`ifdef TMDS_BALANCE_MON_EN
    logic [NUM_CH-1:0]     bal_err;

    modport master (output de, data, ctrl, input symbol, de_o, bal_err);
    modport slave  (input de, data, ctrl, output symbol, de_o, bal_err);
`else
    modport master (output de, data, ctrl, input symbol, de_o);
    modport slave  (input de, data, ctrl, output symbol, de_o);
`endif

endinterface

// File: rtl/tmds_lane_enc.sv
// Single-lane two-stage TMDS encoder owning its running disparity.
// TMDS_BALANCE_MON_EN adds a sticky out-of-range disparity flag.
module tmds_lane_enc
    import tmds_pkg::*;
(
    input  logic       clk_pix,
    input  logic       rst,
    input  logic       de,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    output logic [9:0] symbol
`ifdef TMDS_BALANCE_MON_EN
    ,
    output logic       bal_err
`endif
);

    // Extra headroom only needed to see the next count leave -10..+10.
`ifdef TMDS_BALANCE_MON_EN
    localparam int NXT_W = CNT_W + 2;
`else
    localparam int NXT_W = CNT_W;
`endif
    localparam logic signed [NXT_W-1:0] ZERO  = NXT_W'(0);
    localparam logic signed [NXT_W-1:0] TWO   = NXT_W'(2);
    localparam logic signed [NXT_W-1:0] EIGHT = NXT_W'(8);

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] q_m;

    logic [8:0] q_m_r;
    logic       de_r;
    logic [1:0] ctrl_r;

    logic [3:0]              n1q;
    logic signed [NXT_W-1:0] bias;
    logic signed [NXT_W-1:0] cnt_ext;
    logic signed [NXT_W-1:0] cnt_nxt;
    logic [9:0]              sym_nxt;
    logic signed [CNT_W-1:0] cnt;

    always_comb begin
        n1d      = popcount8(data);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
        q_m      = '0;
        q_m[0]   = data[0];
        for (int i = 1; i < 8; i++)
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
        q_m[8]   = ~use_xnor;
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            q_m_r  <= '0;
            de_r   <= 1'b0;
            ctrl_r <= 2'b00;
        end else begin
            q_m_r  <= q_m;
            de_r   <= de;
            ctrl_r <= ctrl;
        end
    end

    // bias = n1q - n0q = 2*n1q - 8
    always_comb begin
        n1q     = popcount8(q_m_r[7:0]);
        bias    = $signed(NXT_W'({n1q, 1'b0})) - EIGHT;
        cnt_ext = NXT_W'(cnt);
        sym_nxt = ctl_symbol(ctrl_r);
        cnt_nxt = ZERO;
        if (de_r) begin
            if ((cnt == '0) || (n1q == 4'd4)) begin
                sym_nxt = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
                cnt_nxt = q_m_r[8] ? (cnt_ext + bias) : (cnt_ext - bias);
            end else if ((!cnt[CNT_W-1] && (bias > ZERO)) || (cnt[CNT_W-1] && (bias < ZERO))) begin
                sym_nxt = {1'b1, q_m_r[8], ~q_m_r[7:0]};
                cnt_nxt = cnt_ext + (q_m_r[8] ? TWO : ZERO) - bias;
            end else begin
                sym_nxt = {1'b0, q_m_r[8], q_m_r[7:0]};
                cnt_nxt = cnt_ext + bias - (q_m_r[8] ? ZERO : TWO);
            end
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            symbol <= CTL_00;
            cnt    <= '0;
        end else begin
            symbol <= sym_nxt;
            cnt    <= $signed(cnt_nxt[CNT_W-1:0]);
        end
    end

`ifdef TMDS_BALANCE_MON_EN
    localparam logic signed [NXT_W-1:0] LIM = NXT_W'(10);

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) bal_err <= 1'b0;
        else     bal_err <= bal_err || (cnt_nxt > LIM) || (cnt_nxt < -LIM);
    end
`endif

endmodule

// File: rtl/tmds_encoder_n.sv
// NUM_CH-lane DC-balanced TMDS encoder with 2-cycle latency and aligned de_o.
// Optional per-lane balance monitor: define TMDS_BALANCE_MON_EN.
module tmds_encoder_n
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic        clk_pix,
    input  logic        rst,
    tmds_encoder_n_if.slave bus
);

    logic [1:0] de_pipe;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) de_pipe <= 2'b00;
        else     de_pipe <= {de_pipe[0], bus.de};
    end

    assign bus.de_o = de_pipe[1];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        tmds_lane_enc u_lane (
            .clk_pix (clk_pix),
            .rst     (rst),
            .de      (bus.de),
            .data    (bus.data[8*k +: 8]),
            .ctrl    (bus.ctrl[2*k +: 2]),
            .symbol  (bus.symbol[10*k +: 10])
`ifdef TMDS_BALANCE_MON_EN
            ,
            .bal_err (bus.bal_err[k])
`endif
        );
    end

endmodule
